// File: rtl/de2_sram_arbiter_if.sv
// Request/ready memory port bundle shared by requesters and the SRAM controller.
interface de2_sram_arbiter_if #(
  parameter int unsigned ADDR_W = 18,
  parameter int unsigned DATA_W = 16
);
  logic [ADDR_W-1:0] address;
  logic [DATA_W-1:0] to_mem;
  logic [DATA_W-1:0] from_mem;
  logic              req;
  logic              wren;
  logic              ready;

  // Side that issues requests
  modport master (output address, to_mem, req, wren, input from_mem, ready);
  // Side that services requests
  modport slave  (input address, to_mem, req, wren, output from_mem, ready);
endinterface

// File: rtl/de2_sram_arbiter.sv
// Two-port arbiter merging requesters A and B onto the DE2 SRAM controller p1 port.
module de2_sram_arbiter #(
  parameter int unsigned ADDR_W     = 18,
  parameter int unsigned DATA_W     = 16,
  parameter bit          FIXED_PRIO = 1'b0
) (
  input  logic               clk,
  input  logic               rst,
  de2_sram_arbiter_if.slave  a,
  de2_sram_arbiter_if.slave  b,
  de2_sram_arbiter_if.master m,
  output logic               owner,
  output logic               busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  state_t state, state_n;
  logic   prev_a, prev_b;
  logic   pend_a, pend_b;
  logic   last_grant;
  logic   edge_a, edge_b;
  logic   req_a, req_b;
  logic   grant, win_b, done;

  assign edge_a = a.req & ~prev_a;
  assign edge_b = b.req & ~prev_b;
  assign req_a  = edge_a | pend_a;
  assign req_b  = edge_b | pend_b;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // Next-state: IDLE -> ISSUE on grant, ISSUE -> WAIT, WAIT -> IDLE on controller ready
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (grant) state_n = ISSUE;
      ISSUE:   state_n = WAIT;
      WAIT:    if (m.ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Control strobes: winner selection in IDLE, completion in WAIT
  always_comb begin
    grant = 1'b0;
    win_b = 1'b0;
    done  = 1'b0;
    if (state == IDLE && (req_a || req_b)) begin
      grant = 1'b1;
      if (FIXED_PRIO) win_b = ~req_a;
      else            win_b = (req_a && req_b) ? ~last_grant : req_b;
    end
    if (state == WAIT && m.ready) done = 1'b1;
  end

  // Registered outputs, request capture and per-port pending bookkeeping
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_a     <= 1'b0;
      prev_b     <= 1'b0;
      pend_a     <= 1'b0;
      pend_b     <= 1'b0;
      last_grant <= 1'b1;
      m.address  <= ADDR_W'(0);
      m.to_mem   <= DATA_W'(0);
      m.req      <= 1'b0;
      m.wren     <= 1'b0;
      a.from_mem <= DATA_W'(0);
      b.from_mem <= DATA_W'(0);
      a.ready    <= 1'b0;
      b.ready    <= 1'b0;
      owner      <= 1'b0;
      busy       <= 1'b0;
    end else begin
      prev_a <= a.req;
      prev_b <= b.req;
      // On the granting cycle only an edge on top of an already-pending request survives
      pend_a <= (grant && !win_b) ? (pend_a & edge_a) : (pend_a | edge_a);
      pend_b <= (grant &&  win_b) ? (pend_b & edge_b) : (pend_b | edge_b);
      m.req   <= grant;
      a.ready <= done & ~owner;
      b.ready <= done &  owner;
      if (grant) begin
        m.address <= win_b ? b.address : a.address;
        m.to_mem  <= win_b ? b.to_mem  : a.to_mem;
        m.wren    <= win_b ? b.wren    : a.wren;
        owner     <= win_b;
        busy      <= 1'b1;
      end
      if (done) begin
        busy       <= 1'b0;
        last_grant <= owner;
        if (!m.wren) begin
          if (owner) b.from_mem <= m.from_mem;
          else       a.from_mem <= m.from_mem;
        end
      end
    end
  end

endmodule

// File: tb/tb_de2_sram_arbiter.sv
// Directed bench: round-robin (u[0]) and fixed-priority (u[1]) arbiters driven by shared stimulus.
module tb_de2_sram_arbiter;
  localparam int unsigned AW = 18;
  localparam int unsigned DW = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [AW-1:0] a_addr, b_addr;
  logic [DW-1:0] a_wd, b_wd;
  logic          a_pulse, b_pulse, a_wr, b_wr, auto_en;
  int            lat;
  int            n_cmp = 0;
  int            n_err = 0;

  logic          mreq_o [2];
  logic [AW-1:0] maddr_o[2];
  logic [DW-1:0] mto_o  [2];
  logic          mwr_o  [2];
  logic          ardy_o [2];
  logic          brdy_o [2];
  logic [DW-1:0] afm_o  [2];
  logic [DW-1:0] bfm_o  [2];
  logic          own_o  [2];
  logic          busy_o [2];
  int            acnt_o [2];
  int            bcnt_o [2];
  int            mcnt_o [2];
  logic [63:0]   hist_o [2];

  for (genvar g = 0; g < 2; g++) begin : u
    de2_sram_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) a_if ();
    de2_sram_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) b_if ();
    de2_sram_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) m_if ();
    logic owner, busy;

    de2_sram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .FIXED_PRIO(1'(g))) dut (
      .clk(clk), .rst(rst), .a(a_if), .b(b_if), .m(m_if), .owner(owner), .busy(busy)
    );

    // A optionally re-requests in the same cycle its ready pulse arrives
    assign a_if.address = a_addr;
    assign a_if.to_mem  = a_wd;
    assign a_if.wren    = a_wr;
    assign a_if.req     = a_pulse | (auto_en & a_if.ready);
    assign b_if.address = b_addr;
    assign b_if.to_mem  = b_wd;
    assign b_if.wren    = b_wr;
    assign b_if.req     = b_pulse;

    // Controller model: ready pulse lat+1 cycles after the req pulse; unwritten words read addr^0xBFCC
    logic [DW-1:0] mem [0:255];
    logic [255:0]  wv;
    int            cnt;
    always @(posedge clk or posedge rst) begin
      if (rst) begin
        m_if.ready    <= 1'b0;
        m_if.from_mem <= '0;
        cnt           <= 0;
        wv            <= '0;
      end else begin
        m_if.ready <= 1'b0;
        if (m_if.req) cnt <= lat;
        else if (cnt != 0) begin
          cnt <= cnt - 1;
          if (cnt == 1) begin
            m_if.ready <= 1'b1;
            if (m_if.wren) begin
              mem[m_if.address[7:0]] <= m_if.to_mem;
              wv[m_if.address[7:0]]  <= 1'b1;
            end else begin
              m_if.from_mem <= wv[m_if.address[7:0]] ? mem[m_if.address[7:0]]
                                                     : (m_if.address[15:0] ^ 16'hBFCC);
            end
          end
        end
      end
    end

    // Event counters and grant history (newest owner at bit 0)
    int ac = 0, bc = 0, mc = 0;
    logic [63:0] hist = '0;
    always @(posedge clk) begin
      if (a_if.ready) ac <= ac + 1;
      if (b_if.ready) bc <= bc + 1;
      if (m_if.req) begin
        mc   <= mc + 1;
        hist <= {hist[62:0], owner};
      end
    end

    assign mreq_o[g]  = m_if.req;
    assign maddr_o[g] = m_if.address;
    assign mto_o[g]   = m_if.to_mem;
    assign mwr_o[g]   = m_if.wren;
    assign ardy_o[g]  = a_if.ready;
    assign brdy_o[g]  = b_if.ready;
    assign afm_o[g]   = a_if.from_mem;
    assign bfm_o[g]   = b_if.from_mem;
    assign own_o[g]   = owner;
    assign busy_o[g]  = busy;
    assign acnt_o[g]  = ac;
    assign bcnt_o[g]  = bc;
    assign mcnt_o[g]  = mc;
    assign hist_o[g]  = hist;
  end

  task automatic chk(input string tag, input int idx, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s[%0d]: observed 0x%0h expected 0x%0h", tag, idx, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  int sa[2], sb[2], sm[2];

  task automatic snap();
    for (int i = 0; i < 2; i++) begin
      sa[i] = acnt_o[i];
      sb[i] = bcnt_o[i];
      sm[i] = mcnt_o[i];
    end
  endtask

  initial begin
    int n;
    a_pulse = 1'b0; b_pulse = 1'b0; a_wr = 1'b0; b_wr = 1'b0; auto_en = 1'b0;
    a_addr = '0; b_addr = '0; a_wd = '0; b_wd = '0; lat = 1; rst = 1'b1;
    tick(3);
    for (int i = 0; i < 2; i++) begin
      chk("rst_m_req", i, 32'(mreq_o[i]), 32'h0);
      chk("rst_m_addr", i, 32'(maddr_o[i]), 32'h0);
      chk("rst_m_wren", i, 32'(mwr_o[i]), 32'h0);
      chk("rst_a_ready", i, 32'(ardy_o[i]), 32'h0);
      chk("rst_b_ready", i, 32'(brdy_o[i]), 32'h0);
      chk("rst_a_from", i, 32'(afm_o[i]), 32'h0);
      chk("rst_owner", i, 32'(own_o[i]), 32'h0);
      chk("rst_busy", i, 32'(busy_o[i]), 32'h0);
    end
    rst = 1'b0;
    tick(2);

    // Single A read at 0x00123
    snap();
    a_addr = 18'h00123; a_wr = 1'b0; a_pulse = 1'b1;
    tick(1); a_pulse = 1'b0;
    for (int i = 0; i < 2; i++) begin
      chk("t1_m_req_c1", i, 32'(mreq_o[i]), 32'h1);
      chk("t1_m_addr", i, 32'(maddr_o[i]), 32'h00123);
      chk("t1_m_wren", i, 32'(mwr_o[i]), 32'h0);
      chk("t1_owner", i, 32'(own_o[i]), 32'h0);
      chk("t1_busy", i, 32'(busy_o[i]), 32'h1);
    end
    tick(1);
    for (int i = 0; i < 2; i++) chk("t1_m_req_c2", i, 32'(mreq_o[i]), 32'h0);
    tick(1);
    for (int i = 0; i < 2; i++) chk("t1_a_ready_c3", i, 32'(ardy_o[i]), 32'h0);
    tick(1);
    for (int i = 0; i < 2; i++) begin
      chk("t1_a_ready_c4", i, 32'(ardy_o[i]), 32'h1);
      chk("t1_a_from", i, 32'(afm_o[i]), 32'hBEEF);
      chk("t1_busy_c4", i, 32'(busy_o[i]), 32'h0);
    end
    tick(1);
    for (int i = 0; i < 2; i++) begin
      chk("t1_a_ready_c5", i, 32'(ardy_o[i]), 32'h0);
      chk("t1_a_cnt", i, 32'(acnt_o[i] - sa[i]), 32'h1);
      chk("t1_b_cnt", i, 32'(bcnt_o[i] - sb[i]), 32'h0);
      chk("t1_b_from", i, 32'(bfm_o[i]), 32'h0);
    end

    // Single B write 0x5A5A to 0x3FFFF, then read it back through A
    snap();
    b_addr = 18'h3FFFF; b_wd = 16'h5A5A; b_wr = 1'b1; b_pulse = 1'b1;
    tick(1); b_pulse = 1'b0;
    for (int i = 0; i < 2; i++) begin
      chk("t2_m_addr", i, 32'(maddr_o[i]), 32'h3FFFF);
      chk("t2_m_to", i, 32'(mto_o[i]), 32'h5A5A);
      chk("t2_m_wren", i, 32'(mwr_o[i]), 32'h1);
      chk("t2_owner", i, 32'(own_o[i]), 32'h1);
    end
    tick(5);
    for (int i = 0; i < 2; i++) begin
      chk("t2_b_cnt", i, 32'(bcnt_o[i] - sb[i]), 32'h1);
      chk("t2_a_cnt", i, 32'(acnt_o[i] - sa[i]), 32'h0);
    end
    a_addr = 18'h3FFFF; a_pulse = 1'b1;
    tick(1); a_pulse = 1'b0;
    tick(6);
    for (int i = 0; i < 2; i++) begin
      chk("t2_readback", i, 32'(afm_o[i]), 32'h5A5A);
      chk("t2_b_from", i, 32'(bfm_o[i]), 32'h0);
    end

    // Simultaneous edges after reset: A then B, and again A then B
    rst = 1'b1; tick(1); rst = 1'b0; tick(1);
    a_addr = 18'h00123; b_addr = 18'h00040; b_wr = 1'b0;
    for (int r = 0; r < 2; r++) begin
      snap();
      a_pulse = 1'b1; b_pulse = 1'b1;
      tick(1); a_pulse = 1'b0; b_pulse = 1'b0;
      tick(12);
      for (int i = 0; i < 2; i++) begin
        chk("t3_grants", i, 32'(mcnt_o[i] - sm[i]), 32'h2);
        chk("t3_order", i, 32'(hist_o[i][1:0]), 32'h1);
        chk("t3_a_cnt", i, 32'(acnt_o[i] - sa[i]), 32'h1);
        chk("t3_b_cnt", i, 32'(bcnt_o[i] - sb[i]), 32'h1);
        chk("t3_b_from", i, 32'(bfm_o[i]), 32'hBF8C);
      end
    end

    // A re-requests on every ready while B asks once
    snap();
    auto_en = 1'b1; a_pulse = 1'b1; b_pulse = 1'b1;
    tick(1); a_pulse = 1'b0; b_pulse = 1'b0;
    tick(40);
    chk("t4_fp_b_starved", 1, 32'(bcnt_o[1] - sb[1]), 32'h0);
    chk("t4_rr_b_cnt", 0, 32'(bcnt_o[0] - sb[0]), 32'h1);
    n = mcnt_o[0] - sm[0];
    chk("t4_rr_first_a", 0, 32'(hist_o[0][n-1]), 32'h0);
    chk("t4_rr_second_b", 0, 32'(hist_o[0][n-2]), 32'h1);
    auto_en = 1'b0;
    tick(16);
    chk("t4_fp_b_cnt", 1, 32'(bcnt_o[1] - sb[1]), 32'h1);
    chk("t4_fp_last_b", 1, 32'(hist_o[1][0]), 32'h1);
    chk("t4_rr_b_once", 0, 32'(bcnt_o[0] - sb[0]), 32'h1);

    // Two A edges while a slow B write is outstanding merge into one A grant
    lat = 4;
    snap();
    b_addr = 18'h00010; b_wd = 16'h1111; b_wr = 1'b1; a_addr = 18'h00123; a_wr = 1'b0;
    b_pulse = 1'b1; tick(1); b_pulse = 1'b0;
    tick(1); a_pulse = 1'b1; tick(1); a_pulse = 1'b0;
    tick(1); a_pulse = 1'b1; tick(1); a_pulse = 1'b0;
    for (int i = 0; i < 2; i++) begin
      chk("t5_busy_b", i, 32'(busy_o[i]), 32'h1);
      chk("t5_owner_b", i, 32'(own_o[i]), 32'h1);
    end
    tick(12);
    for (int i = 0; i < 2; i++) begin
      chk("t5_grants", i, 32'(mcnt_o[i] - sm[i]), 32'h2);
      chk("t5_order", i, 32'(hist_o[i][1:0]), 32'h2);
      chk("t5_a_cnt", i, 32'(acnt_o[i] - sa[i]), 32'h1);
      chk("t5_b_cnt", i, 32'(bcnt_o[i] - sb[i]), 32'h1);
      chk("t5_a_from", i, 32'(afm_o[i]), 32'hBEEF);
    end

    // Reset during WAIT with both ports pending discards everything
    snap();
    b_addr = 18'h00020; b_wr = 1'b0;
    b_pulse = 1'b1; tick(1); b_pulse = 1'b0;
    tick(1); a_pulse = 1'b1;
    tick(1); a_pulse = 1'b0; b_pulse = 1'b1;
    tick(1); b_pulse = 1'b0;
    rst = 1'b1;
    #1;
    for (int i = 0; i < 2; i++) begin
      chk("t6_busy", i, 32'(busy_o[i]), 32'h0);
      chk("t6_m_addr", i, 32'(maddr_o[i]), 32'h0);
      chk("t6_owner", i, 32'(own_o[i]), 32'h0);
      chk("t6_a_from", i, 32'(afm_o[i]), 32'h0);
    end
    tick(1); rst = 1'b0;
    tick(16);
    for (int i = 0; i < 2; i++) begin
      chk("t6_grants", i, 32'(mcnt_o[i] - sm[i]), 32'h1);
      chk("t6_a_cnt", i, 32'(acnt_o[i] - sa[i]), 32'h0);
      chk("t6_b_cnt", i, 32'(bcnt_o[i] - sb[i]), 32'h0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
